// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: ALU control codes, mul/div op codes and the
// sequencer FSM state encoding. Imported by alu_muldiv_seq.
package alu_defs_pkg;

    // ALU ctrl_i encodings
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    // Mul/div op select (op_i)
    localparam logic MD_MULU = 1'b0;
    localparam logic MD_DIVU = 1'b1;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32x32 unsigned multiply / restoring divide sequencer that
// borrows the shared 32-bit ALU for one add or subtract per cycle.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, op_i         request and op (0 MULU, 1 DIVU), sampled in IDLE
//   a_i, b_i              multiplicand/dividend, multiplier/divisor
//   busy_o, done_o        busy in CALC/DONE; done is a one-cycle pulse
//   hi_o, lo_o            MULU {product hi, lo}; DIVU {remainder, quotient}
//   alu_src1_o/src2_o/ctrl_o, alu_result_i   shared ALU hookup
module alu_muldiv_seq
    import alu_defs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] alu_src1_o,
    output logic [XLEN-1:0] alu_src2_o,
    output logic [3:0]      alu_ctrl_o,
    input  logic [XLEN-1:0] alu_result_i
);

    logic [1:0]      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            op_q;
    logic [XLEN-1:0] hi_q;    // MULU: partial product hi; DIVU: remainder
    logic [XLEN-1:0] lo_q;    // MULU: multiplier/product lo; DIVU: quotient
    logic [XLEN-1:0] opd_q;   // MULU: multiplicand; DIVU: divisor

    logic [XLEN-1:0] mul_sum;
    logic            mul_carry;
    logic [XLEN-1:0] div_r;
    logic            div_msb;
    logic            div_borrow;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_comb begin
        // Divide step: shift remainder left, bringing in the next dividend bit.
        // The bit shifted out of the remainder is kept as a 33rd bit.
        div_msb = hi_q[XLEN-1];
        div_r   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_ctrl_o = ALU_AND;
        if (state_q == ST_CALC) begin
            alu_src2_o = opd_q;
            if (op_q == MD_MULU) begin
                alu_src1_o = hi_q;
                alu_ctrl_o = ALU_ADD;
            end else begin
                alu_src1_o = div_r;
                alu_ctrl_o = ALU_SUB;
            end
        end

        // The ALU has no carry-out, so recover it from the operand and sum MSBs.
        if (lo_q[0]) begin
            mul_sum   = alu_result_i;
            mul_carry = (hi_q[XLEN-1] & opd_q[XLEN-1]) |
                        ((hi_q[XLEN-1] | opd_q[XLEN-1]) & ~alu_result_i[XLEN-1]);
        end else begin
            mul_sum   = hi_q;
            mul_carry = 1'b0;
        end

        // Borrow of r - d; a set 33rd bit means the true r exceeds d, no borrow.
        div_borrow = ~div_msb &
                     ((~div_r[XLEN-1] & opd_q[XLEN-1]) |
                      ((~div_r[XLEN-1] | opd_q[XLEN-1]) & alu_result_i[XLEN-1]));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULU;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        cnt_q <= '0;
                        opd_q <= (op_i == MD_MULU) ? a_i : b_i;
                        if (op_i == MD_DIVU && b_i == '0) begin
                            hi_q    <= a_i;
                            lo_q    <= '1;
                            state_q <= ST_DONE;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= (op_i == MD_MULU) ? b_i : a_i;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q == MD_MULU) begin
                        {hi_q, lo_q} <= {mul_carry, mul_sum, lo_q[XLEN-1:1]};
                    end else begin
                        hi_q <= div_borrow ? div_r : alu_result_i;
                        lo_q <= {lo_q[XLEN-2:0], ~div_borrow};
                    end
                    if (cnt_q == CNT_W'(XLEN-1))
                        state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
